// File: rtl/req_arbiter4.sv
// req_arbiter4: four-requester arbiter, fixed-priority or round-robin,
// with hold-timeout forced release and one-cycle owner masking.
module req_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout_pulse
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam bit               TMO_EN   = (MAX_HOLD != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       id_q, id_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic             tp_q, tp_d;

  logic [3:0] cand;
  logic [1:0] fp_w;
  logic [1:0] rr_w;
  logic [1:0] rr_idx;
  logic       rr_hit;
  logic [1:0] win;

  assign cand = req & ~mask_q;

  always_comb begin
    fp_w = 2'd0;
    priority case (1'b1)
      cand[3]: fp_w = 2'd3;
      cand[2]: fp_w = 2'd2;
      cand[1]: fp_w = 2'd1;
      default: fp_w = 2'd0;
    endcase
  end

  // Rotating search starting just after the last winner.
  always_comb begin
    rr_w   = last_q;
    rr_hit = 1'b0;
    rr_idx = 2'd0;
    for (int i = 1; i < 5; i++) begin
      rr_idx = last_q + 2'(i);
      if (!rr_hit && cand[rr_idx]) begin
        rr_hit = 1'b1;
        rr_w   = rr_idx;
      end
    end
  end

  assign win = rr_en ? rr_w : fp_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    mask_d  = mask_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    tp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        mask_d = 4'b0000;
        if (cand != 4'b0000) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          last_d  = win;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end else if (TMO_EN && cnt_q == HOLD_MAX) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          tp_d    = 1'b1;
          mask_d  = 4'b0001 << id_q;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      id_q    <= 2'd0;
      mask_q  <= 4'b0000;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      tp_q    <= tp_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_id        = id_q;
  assign gnt_valid     = valid_q;
  assign timeout_pulse = tp_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed and model-checked random bench for req_arbiter4.
module tb_req_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rr_en;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout_pulse;

  int n_checks;
  int n_fail;

  req_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .rr_en         (rr_en),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [31:0] eg,
                       input logic [31:0] eid, input logic [31:0] etp);
    chk({tag, "_gnt"}, 32'(gnt), eg);
    chk({tag, "_vld"}, 32'(gnt_valid), (eg != 0) ? 1 : 0);
    chk({tag, "_tp"}, 32'(timeout_pulse), etp);
    if (eg != 0) chk({tag, "_id"}, 32'(gnt_id), eid);
  endtask

  // reference model state
  logic       m_busy;
  int         m_cnt;
  int         m_last;
  int         m_id;
  logic [3:0] m_mask;
  logic [3:0] m_gnt;
  logic       m_tp;
  logic [3:0] m_cand;
  int         m_win;
  logic [3:0] prev_gnt;
  int         hold_len;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    rr_en    = 1'b0;
    #3;
    chk_g("reset", 0, 0, 0);
    chk("reset_id", 32'(gnt_id), 0);
    rst_n = 1'b1;
    tick();

    // 1: fixed priority, release bubble
    req = 4'b1010;
    tick();
    chk_g("t1_a", 'h8, 3, 0);
    req = 4'b0010;
    tick();
    chk_g("t1_rel", 0, 0, 0);
    tick();
    chk_g("t1_b", 'h2, 1, 0);
    req = 4'b0000;
    tick();
    chk_g("t1_end", 0, 0, 0);

    // 2: round-robin order 0,1,2,3,0 from reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rr_en = 1'b1;
    req   = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_g("t2_gnt", 1 << (k % 4), k % 4, 0);
      tick();
      chk_g("t2_hold", 1 << (k % 4), k % 4, 0);
      req = 4'b1111 & ~(4'b0001 << (k % 4));
      tick();
      chk_g("t2_bub", 0, 0, 0);
      req = 4'b1111;
      tick();
    end
    req = 4'b0000;
    tick();
    chk_g("t2_end", 0, 0, 0);

    // 3: hold timeout and one-cycle mask
    rr_en = 1'b0;
    req   = 4'b0100;
    tick();
    chk_g("t3_c1", 'h4, 2, 0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk_g("t3_hold", 'h4, 2, 0);
    end
    tick();
    chk_g("t3_tmo", 0, 0, 1);
    tick();
    chk_g("t3_mask", 0, 0, 0);
    tick();
    chk_g("t3_regnt", 'h4, 2, 0);
    // owner drops on the very edge the timeout would fire
    for (int i = 2; i <= 8; i++) tick();
    chk_g("t3_c8", 'h4, 2, 0);
    req = 4'b0000;
    tick();
    chk_g("t3_simul", 0, 0, 0);
    req = 4'b0100;
    tick();
    chk_g("t3_nomask", 'h4, 2, 0);
    req = 4'b0000;
    tick();

    // 4: no preemption
    req = 4'b0010;
    tick();
    chk_g("t4_a", 'h2, 1, 0);
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_g("t4_nopre", 'h2, 1, 0);
    end
    req = 4'b1000;
    tick();
    chk_g("t4_rel", 0, 0, 0);
    tick();
    chk_g("t4_b", 'h8, 3, 0);
    req = 4'b0000;
    tick();

    // 5: async reset mid-grant
    req = 4'b0100;
    tick();
    chk_g("t5_a", 'h4, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_g("t5_rst", 0, 0, 0);
    rst_n = 1'b1;
    rr_en = 1'b1;
    req   = 4'b1111;
    tick();
    chk_g("t5_rr0", 'h1, 0, 0);
    req = 4'b0000;
    tick();

    // 6: random stimulus against reference model
    rst_n = 1'b0;
    #1;
    rst_n    = 1'b1;
    m_busy   = 1'b0;
    m_cnt    = 0;
    m_last   = 3;
    m_id     = 0;
    m_mask   = 4'b0000;
    m_gnt    = 4'b0000;
    m_tp     = 1'b0;
    prev_gnt = 4'b0000;
    hold_len = 0;
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
      m_tp = 1'b0;
      if (!m_busy) begin
        m_cand = req & ~m_mask;
        m_mask = 4'b0000;
        if (m_cand != 4'b0000) begin
          m_win = 0;
          if (!rr_en) begin
            for (int b = 0; b < 4; b++)
              if (m_cand[b]) m_win = b;
          end else begin
            for (int s = 4; s >= 1; s--)
              if (m_cand[(m_last + s) % 4]) m_win = (m_last + s) % 4;
          end
          m_busy = 1'b1;
          m_gnt  = 4'b0001 << m_win;
          m_id   = m_win;
          m_last = m_win;
          m_cnt  = 1;
        end
      end else if (!req[m_id]) begin
        m_busy = 1'b0;
        m_gnt  = 4'b0000;
      end else if (m_cnt == 8) begin
        m_busy = 1'b0;
        m_gnt  = 4'b0000;
        m_tp   = 1'b1;
        m_mask = 4'b0001 << m_id;
      end else begin
        m_cnt++;
      end
      tick();
      chk_g("rnd", 32'(m_gnt), 32'(m_id), 32'(m_tp));
      chk("rnd_1hot", 32'($onehot0(gnt)), 1);
      if (gnt != 4'b0000 && gnt == prev_gnt) hold_len++;
      else if (gnt != 4'b0000) hold_len = 1;
      else hold_len = 0;
      prev_gnt = gnt;
      chk("rnd_hold", (hold_len <= 8) ? 1 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
